// File: rtl/lfsr_seq_monitor.sv
// Serial monitor for an LFSR bit stream. It assembles the bits into words,
// counts overlapping 1011 patterns and flags a generator that is stuck at one value.
module lfsr_seq_monitor #(
   parameter int WORD_W    = 8,
   parameter int CNT_W     = 8,
   parameter int STUCK_LEN = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              bit_in,
   input  logic              bit_en,
   input  logic              clear,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   output logic              match,
   output logic [CNT_W-1:0]  match_count,
   output logic              stuck
);

   localparam int SC_W  = $clog2(WORD_W + 1);
   localparam int RUN_W = $clog2(STUCK_LEN + 1);
   localparam logic [SC_W-1:0]  CNT_LAST = SC_W'(WORD_W - 1);
   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STUCK_LEN);

   typedef enum logic [1:0] {S0, S1, S10, S101} state_t;

   state_t              state_reg, state_next;
   logic                hit_next;
   logic [WORD_W-1:0]   shift_reg, shift_next;
   logic [SC_W-1:0]     sample_cnt_reg;
   logic [RUN_W-1:0]    run_reg, run_next;
   logic                last_bit_reg;

   always_comb begin
      shift_next = {shift_reg[WORD_W-2:0], bit_in};
      state_next = S0;
      hit_next   = 1'b0;
      case (state_reg)
         S0:   state_next = bit_in ? S1 : S0;
         S1:   state_next = bit_in ? S1 : S10;
         S10:  state_next = bit_in ? S101 : S0;
         S101: begin
            state_next = bit_in ? S1 : S10;
            hit_next   = bit_in;
         end
         default: state_next = S0;
      endcase
      // A zero run length marks the first sample after reset or clear.
      if (run_reg == '0 || bit_in != last_bit_reg)
         run_next = RUN_W'(1);
      else if (run_reg == RUN_MAX)
         run_next = run_reg;
      else
         run_next = run_reg + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= S0;
         shift_reg      <= '0;
         sample_cnt_reg <= '0;
         run_reg        <= '0;
         last_bit_reg   <= 1'b0;
         word_out       <= '0;
         word_valid     <= 1'b0;
         match          <= 1'b0;
         match_count    <= '0;
         stuck          <= 1'b0;
      end else begin
         match      <= 1'b0;
         word_valid <= 1'b0;
         if (clear) begin
            state_reg      <= S0;
            sample_cnt_reg <= '0;
            run_reg        <= '0;
            match_count    <= '0;
            stuck          <= 1'b0;
         end else if (bit_en) begin
            shift_reg    <= shift_next;
            state_reg    <= state_next;
            last_bit_reg <= bit_in;
            run_reg      <= run_next;
            if (run_next == RUN_MAX)
               stuck <= 1'b1;
            if (hit_next) begin
               match <= 1'b1;
               if (match_count != '1)
                  match_count <= match_count + 1'b1;
            end
            if (sample_cnt_reg == CNT_LAST) begin
               word_out       <= shift_next;
               word_valid     <= 1'b1;
               sample_cnt_reg <= '0;
            end else begin
               sample_cnt_reg <= sample_cnt_reg + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_lfsr_seq_monitor.sv
// Self-checking bench for lfsr_seq_monitor: vector table, directed corner
// sequences and randomized traffic against a history-based reference model.
module tb_lfsr_seq_monitor;

   localparam int WORD_W    = 8;
   localparam int CNT_W     = 8;
   localparam int STUCK_LEN = 16;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              bit_in = 1'b0;
   logic              bit_en = 1'b0;
   logic              clear = 1'b0;
   logic [WORD_W-1:0] word_out;
   logic              word_valid;
   logic              match;
   logic [CNT_W-1:0]  match_count;
   logic              stuck;

   lfsr_seq_monitor #(.WORD_W(WORD_W), .CNT_W(CNT_W), .STUCK_LEN(STUCK_LEN)) dut (
      .clock(clock), .reset(reset), .bit_in(bit_in), .bit_en(bit_en), .clear(clear),
      .word_out(word_out), .word_valid(word_valid), .match(match),
      .match_count(match_count), .stuck(stuck)
   );

   always #5 clock = ~clock;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: history of sampled bits since the last reset/clear.
   bit                m_hist[$];
   int                m_nsamp = 0;
   int                m_nmatch = 0;
   bit                m_stuck = 0;
   logic [WORD_W-1:0] m_word = '0;
   bit                m_match = 0;
   bit                m_wv = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hist.delete();
      m_nsamp = 0; m_nmatch = 0; m_stuck = 0; m_word = '0; m_match = 0; m_wv = 0;
   endtask

   task automatic model_clear();
      m_hist.delete();
      m_nsamp = 0; m_nmatch = 0; m_stuck = 0; m_match = 0; m_wv = 0;
   endtask

   task automatic model_sample(input bit b);
      int n, run;
      m_hist.push_back(b);
      if (m_hist.size() > 40) void'(m_hist.pop_front());
      n = m_hist.size();
      m_nsamp++;
      m_match = (n >= 4) && m_hist[n-4] == 1 && m_hist[n-3] == 0 &&
                m_hist[n-2] == 1 && m_hist[n-1] == 1;
      if (m_match) m_nmatch++;
      m_wv = (m_nsamp % WORD_W) == 0;
      if (m_wv)
         for (int i = 0; i < WORD_W; i++) m_word[WORD_W-1-i] = m_hist[n-WORD_W+i];
      run = 1;
      for (int j = n - 2; j >= 0 && run < STUCK_LEN; j--) begin
         if (m_hist[j] != m_hist[n-1]) break;
         run++;
      end
      if (run >= STUCK_LEN) m_stuck = 1;
   endtask

   task automatic chk_all();
      int sat;
      sat = (m_nmatch > 255) ? 255 : m_nmatch;
      chk("match", match, m_match);
      chk("word_valid", word_valid, m_wv);
      chk("word_out", word_out, m_word);
      chk("match_count", match_count, sat);
      chk("stuck", stuck, m_stuck);
   endtask

   task automatic step(input logic c, input logic e, input logic b);
      clear = c; bit_en = e; bit_in = b;
      @(posedge clock);
      if (c) model_clear();
      else if (e) model_sample(b);
      else begin m_match = 0; m_wv = 0; end
      #1;
      chk_all();
   endtask

   task automatic do_reset(input int n);
      reset = 1; clear = 0; bit_en = 1; bit_in = 1;
      repeat (n) begin
         @(posedge clock);
         model_reset();
         #1;
         chk_all();
      end
      reset = 0;
      step(0, 1, 1);
   endtask

   typedef struct {
      logic       en;
      logic       b;
      logic       exp_match;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t tbl[7];
   int   wv_pulses;
   bit   rb;

   initial begin
      tbl[0] = '{1'b1, 1'b1, 1'b0, 8'd0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 8'd0};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 8'd0};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 8'd1};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 8'd1};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 8'd1};
      tbl[6] = '{1'b1, 1'b1, 1'b1, 8'd2};

      // Reset held two cycles with a live sample strobe.
      do_reset(2);
      chk("rst_match_count", match_count, 0);
      step(1, 0, 0);

      // Overlapping 1011 detection from the vector table.
      for (int i = 0; i < 7; i++) begin
         step(0, tbl[i].en, tbl[i].b);
         chk("tbl_match", match, tbl[i].exp_match);
         chk("tbl_count", match_count, tbl[i].exp_cnt);
      end

      // Word assembly with idle cycles between samples.
      do_reset(1);
      step(1, 0, 0);
      wv_pulses = 0;
      begin
         logic [7:0] pat;
         pat = 8'b1010_0110;
         for (int i = 7; i >= 0; i--) begin
            step(0, 1, pat[i]);
            if (word_valid) wv_pulses++;
            if (i == 0) begin
               chk("word_a6", word_out, 8'hA6);
               chk("word_a6_valid", word_valid, 1);
            end
            step(0, 0, 0);
            if (word_valid) wv_pulses++;
         end
      end
      chk("word_pulses", wv_pulses, 1);

      // Stuck detection: 15 zeros then a one, then 16 zeros.
      step(1, 0, 0);
      for (int i = 0; i < 15; i++) step(0, 1, 0);
      step(0, 1, 1);
      chk("stuck_15", stuck, 0);
      step(1, 0, 0);
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 0);
         if (i == 14) chk("stuck_pre", stuck, 0);
      end
      chk("stuck_16", stuck, 1);
      for (int i = 0; i < 5; i++) step(0, 1, i[0]);
      chk("stuck_hold", stuck, 1);
      step(1, 0, 0);
      chk("stuck_clear", stuck, 0);

      // Saturation after 300 overlapping matches.
      for (int i = 0; i < 300; i++) begin
         step(0, 1, 1); step(0, 1, 0); step(0, 1, 1); step(0, 1, 1);
      end
      chk("sat_255", match_count, 255);

      // Clear on the completing bit discards the match.
      step(1, 0, 0);
      step(0, 1, 1); step(0, 1, 0); step(0, 1, 1);
      step(1, 1, 1);
      chk("clr_no_match", match, 0);
      chk("clr_count", match_count, 0);
      step(0, 1, 1); step(0, 1, 0); step(0, 1, 1); step(0, 1, 1);
      chk("clr_restart_match", match, 1);
      chk("clr_restart_count", match_count, 1);

      // Reset in the middle of a partial match and partial word.
      step(0, 1, 1); step(0, 1, 0); step(0, 1, 1);
      do_reset(1);
      chk("mid_reset_match", match, 0);
      chk("mid_reset_word", word_out, 0);

      // Randomized traffic with occasional clear/reset and long runs.
      rb = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset(1);
         if ($urandom_range(0, 9) >= 8) rb = ~rb;
         step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
              ($urandom_range(0, 3) == 0) ? 1'($urandom) : rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
